// File: rtl/data_memory_responder.sv
// Data-memory responder: word-addressed RAM plus a small MMIO window (LEDs, switches,
// cycle counter, compare timer, sticky status). Reads are combinational; stores commit on the edge.
module data_memory_responder #(
  parameter int RAM_ADDR_BITS = 10,
  parameter int LED_WIDTH     = 18,
  parameter int SW_WIDTH      = 18
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [31:0]          memory_address,
  input  logic [31:0]          memory_write_value,
  input  logic                 memory_write_enable,
  output logic [31:0]          memory_read_value,
  input  logic [SW_WIDTH-1:0]  switches,
  output logic [LED_WIDTH-1:0] LEDR,
  output logic                 timer_flag,
  output logic                 bus_error
);

  localparam int RAM_DEPTH = 1 << RAM_ADDR_BITS;

  // Word addresses (byte address >> 2) of the I/O registers at 0xFFFF0000..0xFFFF0010
  localparam logic [29:0] LED_WORD     = 30'h3FFF_C000;
  localparam logic [29:0] SW_WORD      = 30'h3FFF_C001;
  localparam logic [29:0] CYCLE_WORD   = 30'h3FFF_C002;
  localparam logic [29:0] COMPARE_WORD = 30'h3FFF_C003;
  localparam logic [29:0] STATUS_WORD  = 30'h3FFF_C004;

  logic [29:0]              word_addr;
  logic [RAM_ADDR_BITS-1:0] ram_index;
  logic                     is_ram, is_led, is_sw, is_cycle, is_compare, is_status, is_mapped;
  logic                     unused_addr_bits;

  logic [31:0] ram [RAM_DEPTH];

  logic [LED_WIDTH-1:0] led_reg, led_next;
  logic [SW_WIDTH-1:0]  sw_meta_reg, sw_sync_reg;
  logic [31:0]          cycle_reg, cycle_next;
  logic [31:0]          compare_reg, compare_next;
  logic                 timer_flag_reg, timer_flag_next;
  logic                 bus_error_reg, bus_error_next;
  logic [1:0]           status_clear;

  assign word_addr        = memory_address[31:2];
  assign ram_index        = memory_address[RAM_ADDR_BITS+1:2];
  assign unused_addr_bits = ^memory_address[1:0];

  assign is_ram     = (memory_address[31:RAM_ADDR_BITS+2] == '0);
  assign is_led     = (word_addr == LED_WORD);
  assign is_sw      = (word_addr == SW_WORD);
  assign is_cycle   = (word_addr == CYCLE_WORD);
  assign is_compare = (word_addr == COMPARE_WORD);
  assign is_status  = (word_addr == STATUS_WORD);
  assign is_mapped  = is_ram | is_led | is_sw | is_cycle | is_compare | is_status;

  // Read path has no side effects: the processor presents an address every cycle
  always_comb begin
    memory_read_value = '0;
    if (is_ram) begin
      memory_read_value = ram[ram_index];
    end else if (is_led) begin
      memory_read_value[LED_WIDTH-1:0] = led_reg;
    end else if (is_sw) begin
      memory_read_value[SW_WIDTH-1:0] = sw_sync_reg;
    end else if (is_cycle) begin
      memory_read_value = cycle_reg;
    end else if (is_compare) begin
      memory_read_value = compare_reg;
    end else if (is_status) begin
      memory_read_value[1:0] = {bus_error_reg, timer_flag_reg};
    end
  end

  // RAM contents are deliberately not reset
  always_ff @(posedge clock) begin
    if (memory_write_enable && is_ram) begin
      ram[ram_index] <= memory_write_value;
    end
  end

  always_comb begin
    led_next     = led_reg;
    compare_next = compare_reg;
    status_clear = 2'b00;
    if (memory_write_enable && is_led) begin
      led_next = memory_write_value[LED_WIDTH-1:0];
    end
    if (memory_write_enable && is_compare) begin
      compare_next = memory_write_value;
    end
    if (memory_write_enable && is_status) begin
      status_clear = memory_write_value[1:0];
    end
    cycle_next      = (memory_write_enable && is_cycle) ? 32'd0 : cycle_reg + 32'd1;
    // Set beats a simultaneous write-1-to-clear on both sticky bits
    timer_flag_next = (cycle_reg == compare_reg) | (timer_flag_reg & ~status_clear[0]);
    bus_error_next  = (memory_write_enable & ~is_mapped) | (bus_error_reg & ~status_clear[1]);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      led_reg        <= '0;
      sw_meta_reg    <= '0;
      sw_sync_reg    <= '0;
      cycle_reg      <= '0;
      compare_reg    <= '0;
      timer_flag_reg <= 1'b0;
      bus_error_reg  <= 1'b0;
    end else begin
      led_reg        <= led_next;
      sw_meta_reg    <= switches;
      sw_sync_reg    <= sw_meta_reg;
      cycle_reg      <= cycle_next;
      compare_reg    <= compare_next;
      timer_flag_reg <= timer_flag_next;
      bus_error_reg  <= bus_error_next;
    end
  end

  assign LEDR       = led_reg;
  assign timer_flag = timer_flag_reg;
  assign bus_error  = bus_error_reg;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: a per-cycle check against a behavioural model of the
// memory map, plus hand-computed literal expectations at the interesting points.
module tb_data_memory_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] memory_address;
  logic [31:0] memory_write_value;
  logic        memory_write_enable;
  logic [31:0] memory_read_value;
  logic [17:0] switches;
  logic [17:0] LEDR;
  logic        timer_flag;
  logic        bus_error;

  int tests = 0;
  int fails = 0;

  data_memory_responder dut (
    .clock              (clock),
    .reset              (reset),
    .memory_address     (memory_address),
    .memory_write_value (memory_write_value),
    .memory_write_enable(memory_write_enable),
    .memory_read_value  (memory_read_value),
    .switches           (switches),
    .LEDR               (LEDR),
    .timer_flag         (timer_flag),
    .bus_error          (bus_error)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // Behavioural model of the visible memory map
  logic [31:0] m_ram [int];
  logic [17:0] m_led;
  logic [31:0] m_cycle, m_cmp;
  logic        m_flag, m_berr;
  logic [17:0] m_sw_hist [$];   // switch samples, newest first; entry 1 is what software sees

  function automatic logic [31:0] model_read(input logic [31:0] a, output bit known);
    known = 1'b1;
    if (a < 32'h0000_1000) begin
      if (m_ram.exists(int'(a >> 2))) return m_ram[int'(a >> 2)];
      known = 1'b0;
      return 32'd0;
    end
    case (a & 32'hFFFF_FFFC)
      32'hFFFF_0000: return {14'd0, m_led};
      32'hFFFF_0004: return {14'd0, m_sw_hist[1]};
      32'hFFFF_0008: return m_cycle;
      32'hFFFF_000C: return m_cmp;
      32'hFFFF_0010: return {30'd0, m_berr, m_flag};
      default:       return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_led = '0; m_cycle = '0; m_cmp = '0; m_flag = 1'b0; m_berr = 1'b0;
    m_sw_hist = {18'd0, 18'd0};
  endtask

  task automatic model_edge();
    logic [31:0] a, d;
    bit match, clr_cycle, clr0, clr1, unmapped;
    a = memory_address & 32'hFFFF_FFFC;
    d = memory_write_value;
    match = (m_cycle == m_cmp);
    clr_cycle = 1'b0; clr0 = 1'b0; clr1 = 1'b0; unmapped = 1'b0;
    if (memory_write_enable) begin
      if (a < 32'h0000_1000) m_ram[int'(a >> 2)] = d;
      else if (a == 32'hFFFF_0000) m_led = d[17:0];
      else if (a == 32'hFFFF_0004) ;
      else if (a == 32'hFFFF_0008) clr_cycle = 1'b1;
      else if (a == 32'hFFFF_000C) m_cmp = d;
      else if (a == 32'hFFFF_0010) begin clr0 = d[0]; clr1 = d[1]; end
      else unmapped = 1'b1;
    end
    m_cycle = clr_cycle ? 32'd0 : m_cycle + 32'd1;
    if (match) m_flag = 1'b1; else if (clr0) m_flag = 1'b0;
    if (unmapped) m_berr = 1'b1; else if (clr1) m_berr = 1'b0;
    m_sw_hist.push_front(switches);
    void'(m_sw_hist.pop_back());
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [31:0] a, input logic [31:0] d, input logic we);
    memory_address = a;
    memory_write_value = d;
    memory_write_enable = we;
  endtask

  // One bus cycle: compare everything against the model mid-cycle, then advance both on the edge
  task automatic tick();
    bit known;
    logic [31:0] er;
    @(negedge clock);
    er = model_read(memory_address, known);
    check("LEDR", {14'd0, LEDR}, {14'd0, m_led});
    check("timer_flag", {31'd0, timer_flag}, {31'd0, m_flag});
    check("bus_error", {31'd0, bus_error}, {31'd0, m_berr});
    if (known) check("read_value", memory_read_value, er);
    @(posedge clock);
    model_edge();
    #1;
    $display("[TB] addr=%h wdata=%h we=%0d rdata=%h led=%h flag=%0d berr=%0d",
             memory_address, memory_write_value, memory_write_enable,
             memory_read_value, LEDR, timer_flag, bus_error);
  endtask

  logic [31:0] tbl_a [4] = '{32'h0000_0000, 32'h0000_0FFC, 32'h0000_0404, 32'h0000_1000};
  logic [31:0] tbl_d [4] = '{32'h1111_1111, 32'hCAFE_F00D, 32'hA5A5_5A5A, 32'hBAD0_BAD0};

  initial begin
    reset = 1'b1;
    switches = '0;
    set_in(32'hFFFF_0008, 32'd0, 1'b0);
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("reset_LEDR", {14'd0, LEDR}, 32'd0);
    check("reset_flag", {31'd0, timer_flag}, 32'd0);
    check("reset_berr", {31'd0, bus_error}, 32'd0);
    check("reset_cycle", memory_read_value, 32'd0);
    reset = 1'b0;

    // RAM store: pre-store value in the same cycle, new value afterwards, byte aliasing
    set_in(32'h0000_0010, 32'd0, 1'b1); tick();
    set_in(32'h0000_0010, 32'hDEAD_BEEF, 1'b1); #1;
    check("ram_same_cycle", memory_read_value, 32'd0);
    tick();
    check("ram_next_cycle", memory_read_value, 32'hDEAD_BEEF);
    set_in(32'h0000_0013, 32'd0, 1'b0); #1;
    check("ram_misaligned", memory_read_value, 32'hDEAD_BEEF);
    tick();

    // LED register, then asynchronous reset mid-cycle
    set_in(32'hFFFF_0000, 32'h0003_FFFF, 1'b1); tick();
    check("led_write", {14'd0, LEDR}, 32'h0003_FFFF);
    check("led_read", memory_read_value, 32'h0003_FFFF);
    set_in(32'hFFFF_0000, 32'd0, 1'b0);
    #1 reset = 1'b1;
    #1;
    check("async_reset_LEDR", {14'd0, LEDR}, 32'd0);
    check("async_reset_read", memory_read_value, 32'd0);
    model_reset();
    @(posedge clock);
    #1 reset = 1'b0;

    // Switch synchronizer latency and ignored store to SW
    set_in(32'hFFFF_0004, 32'd0, 1'b0);
    switches = 18'h00155;
    tick();
    check("sw_after_1_edge", memory_read_value, 32'd0);
    tick();
    check("sw_after_2_edges", memory_read_value, 32'h0000_0155);
    set_in(32'hFFFF_0004, 32'hFFFF_FFFF, 1'b1); tick();
    check("sw_store_ignored", memory_read_value, 32'h0000_0155);
    check("sw_store_no_berr", {31'd0, bus_error}, 32'd0);

    // Compare timer
    set_in(32'hFFFF_000C, 32'd20, 1'b1); tick();
    set_in(32'hFFFF_0008, 32'd0, 1'b1); tick();
    set_in(32'hFFFF_0010, 32'd1, 1'b1); tick();
    check("flag_cleared", {31'd0, timer_flag}, 32'd0);
    set_in(32'hFFFF_0010, 32'd0, 1'b0);
    repeat (19) tick();
    check("flag_before_match", {31'd0, timer_flag}, 32'd0);
    tick();
    check("flag_at_match", {31'd0, timer_flag}, 32'd1);
    check("status_flag", memory_read_value, 32'h0000_0001);
    set_in(32'hFFFF_000C, 32'd23, 1'b1); tick();
    set_in(32'hFFFF_0010, 32'd0, 1'b0); tick();
    set_in(32'hFFFF_0010, 32'd1, 1'b1); tick();
    check("w1c_on_match_set_wins", {31'd0, timer_flag}, 32'd1);
    set_in(32'hFFFF_0010, 32'd1, 1'b1); tick();
    check("w1c_clears_flag", {31'd0, timer_flag}, 32'd0);
    set_in(32'hFFFF_0008, 32'd0, 1'b0); #1;
    check("cycle_value", memory_read_value, 32'd25);
    set_in(32'hFFFF_0008, 32'd123, 1'b1); tick();
    check("cycle_write_wins", memory_read_value, 32'd0);
    set_in(32'hFFFF_0008, 32'd0, 1'b0); tick();
    check("cycle_resumes", memory_read_value, 32'd1);

    // Unmapped store and load
    set_in(32'h8000_0000, 32'h1234_5678, 1'b1); tick();
    check("unmapped_berr", {31'd0, bus_error}, 32'd1);
    set_in(32'h8000_0000, 32'd0, 1'b0); #1;
    check("unmapped_read", memory_read_value, 32'd0);
    set_in(32'hFFFF_0010, 32'd0, 1'b0); #1;
    check("status_berr", memory_read_value, 32'h0000_0002);
    set_in(32'h0000_0010, 32'd0, 1'b0); #1;
    check("ram_untouched", memory_read_value, 32'hDEAD_BEEF);
    tick();
    set_in(32'hFFFF_0010, 32'd2, 1'b1); tick();
    check("berr_w1c", {31'd0, bus_error}, 32'd0);

    // RAM boundaries: first word, last word, middle, and first address past the RAM
    for (int i = 0; i < 4; i++) begin
      set_in(tbl_a[i], tbl_d[i], 1'b1); tick();
    end
    for (int i = 0; i < 4; i++) begin
      set_in(tbl_a[i], 32'd0, 1'b0); tick();
    end
    set_in(32'h0000_0FFC, 32'd0, 1'b0); #1;
    check("ram_last_word", memory_read_value, 32'hCAFE_F00D);
    set_in(32'h0000_1000, 32'd0, 1'b0); #1;
    check("past_ram_read", memory_read_value, 32'd0);
    check("past_ram_berr", {31'd0, bus_error}, 32'd1);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
